pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the Group-K datapath: holds the PC register and selects the next PC each cycle from increment-by-STEP, branch/jump target, call and return. It generalises the fixed 16-bit +1 PC incrementer by adding configurable width and step, a reset vector, stall, and a RAS_DEPTH-entry circular return-address stack with full/empty flags and an error pulse. It sits between the branch/control unit and the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with stall and a circular return-address stack.
// The next PC comes from increment-by-STEP, a branch or call target, or a return-stack pop.
module pc_sequencer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);
    localparam logic [CW-1:0]    FULL_C  = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_plus;
    logic [PW-1:0]    w_ptr_dec;
    logic             w_empty;
    logic             w_full;
    logic             w_push;

    // r_ptr is the next write slot; when the stack is full it also names the oldest entry.
    assign w_pc_plus = r_pc + STEP_W;
    assign w_ptr_dec = r_ptr - PW'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_C);
    assign w_push    = !rst && !stall && !ret_en && call_en;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_ptr] <= w_pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_W;
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!stall) begin
                if (ret_en) begin
                    if (w_empty) begin
                        r_pc  <= w_pc_plus;
                        r_err <= 1'b1;
                    end else begin
                        r_pc    <= r_stack[w_ptr_dec];
                        r_ptr   <= w_ptr_dec;
                        r_count <= r_count - CW'(1);
                    end
                end else if (call_en) begin
                    r_pc  <= branch_target;
                    r_ptr <= r_ptr + PW'(1);
                    if (w_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end else if (branch_en) begin
                    r_pc <= branch_target;
                end else begin
                    r_pc <= w_pc_plus;
                end
            end
        end
    end

    assign pc        = r_pc;
    assign pc_plus   = w_pc_plus;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checks of pc_sequencer against a queue-based model of the PC and return stack.
module tb_pc_sequencer;

    localparam int W     = 16;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         branch_en;
    logic         call_en;
    logic         ret_en;
    logic [W-1:0] branch_target;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_err;

    logic         idle8;
    logic [7:0]   tgt8;
    logic [7:0]   pc8;
    logic [7:0]   pc8_plus;
    logic         empty8;
    logic         full8;
    logic         err8;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_pc;
    logic         m_err;
    logic [W-1:0] ras_q[$];

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(W), .STEP(STEP), .RESET_PC(0), .RAS_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .call_en(call_en), .ret_en(ret_en), .branch_target(branch_target),
        .pc(pc), .pc_plus(pc_plus), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_err(ras_err)
    );

    pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_PC(8'hF8), .RAS_DEPTH(4)) u_wrap (
        .clk(clk), .rst(rst), .stall(idle8), .branch_en(idle8),
        .call_en(idle8), .ret_en(idle8), .branch_target(tgt8),
        .pc(pc8), .pc_plus(pc8_plus), .ras_empty(empty8), .ras_full(full8),
        .ras_err(err8)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: the stack is a plain list of return addresses, newest at the back.
    task automatic model_update(input logic r, input logic s, input logic rt,
                                input logic c, input logic b, input logic [W-1:0] t);
        logic [W-1:0] plus;
        plus = m_pc + W'(STEP);
        m_err = 1'b0;
        if (r) begin
            m_pc = '0;
            ras_q.delete();
        end else if (s) begin
            m_err = 1'b0;
        end else if (rt) begin
            if (ras_q.size() == 0) begin
                m_pc  = plus;
                m_err = 1'b1;
            end else begin
                m_pc = ras_q.pop_back();
            end
        end else if (c) begin
            ras_q.push_back(plus);
            if (ras_q.size() > DEPTH) begin
                void'(ras_q.pop_front());
                m_err = 1'b1;
            end
            m_pc = t;
        end else if (b) begin
            m_pc = t;
        end else begin
            m_pc = plus;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rt, input logic c,
                        input logic b, input logic [W-1:0] t, input string tag);
        rst = r; stall = s; ret_en = rt; call_en = c; branch_en = b; branch_target = t;
        @(posedge clk);
        model_update(r, s, rt, c, b, t);
        #1;
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus"}, pc_plus, m_pc + W'(STEP));
        check({tag, ".empty"}, W'(ras_empty), W'(ras_q.size() == 0));
        check({tag, ".full"}, W'(ras_full), W'(ras_q.size() == DEPTH));
        check({tag, ".err"}, W'(ras_err), W'(m_err));
    endtask

    initial begin
        int exp_ret[5];
        exp_ret = '{51, 41, 31, 21, 22};
        idle8 = 1'b0;
        tgt8  = 8'h00;
        m_pc  = '0;
        m_err = 1'b0;

        step(1, 0, 0, 0, 0, 16'h0, "reset");
        check("reset_pc_const", pc, 16'h0000);
        check("reset_plus_const", pc_plus, 16'h0001);
        check("wrap_reset", W'(pc8), 16'h00F8);
        check("wrap_reset_plus", W'(pc8_plus), 16'h00FC);

        step(0, 0, 0, 0, 0, 16'h0, "run1");
        check("wrap_fc", W'(pc8), 16'h00FC);
        step(0, 0, 0, 0, 0, 16'h0, "run2");
        check("wrap_00", W'(pc8), 16'h0000);
        check("wrap_err", W'(err8), 16'h0000);
        step(0, 0, 0, 0, 0, 16'h0, "run3");
        check("run3_const", pc, 16'h0003);
        step(0, 0, 0, 0, 0, 16'h0, "run4");
        step(0, 0, 0, 0, 0, 16'h0, "run5");
        check("at5_const", pc, 16'h0005);

        step(0, 0, 0, 1, 0, 16'h0040, "call40");
        check("call40_const", pc, 16'h0040);
        step(0, 0, 0, 0, 0, 16'h0, "run41");
        step(0, 0, 0, 0, 0, 16'h0, "run42");
        step(0, 0, 1, 0, 0, 16'h0, "ret6");
        check("ret6_const", pc, 16'h0006);
        check("ret6_empty", W'(ras_empty), 16'h0001);

        step(0, 0, 0, 0, 1, 16'd10, "br10");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, W'(20 + 10 * i), "ovf_call");
        end
        check("ovf_err_const", W'(ras_err), 16'h0001);
        check("ovf_full_const", W'(ras_full), 16'h0001);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 16'h0, "ovf_ret");
            check("ovf_ret_const", pc, W'(exp_ret[i]));
        end
        check("unf_err_const", W'(ras_err), 16'h0001);

        step(0, 0, 0, 0, 1, 16'h002F, "br2f");
        step(0, 0, 0, 1, 0, 16'h0080, "call80");
        step(0, 0, 1, 1, 0, 16'h0099, "callret");
        check("callret_const", pc, 16'h0030);
        check("callret_empty", W'(ras_empty), 16'h0001);
        step(0, 1, 0, 0, 1, 16'h0077, "stallbr");
        check("stall_const", pc, 16'h0030);
        step(0, 0, 0, 1, 0, 16'h0050, "call50");
        step(1, 0, 0, 1, 0, 16'h0060, "rstcall");
        check("rstcall_const", pc, 16'h0000);
        check("rstcall_empty", W'(ras_empty), 16'h0001);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, W'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
